// File: rtl/program_loader.sv
// Boot loader: pulls a little-endian length header and 32-bit words from the UART and writes them to instruction memory.
// Optional trailer checksum byte enabled with `define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int LEN_WIDTH     = 16,
    parameter int MEM_BIT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [LEN_WIDTH-1:0] uart_buf_len,
    output logic                 uart_out_valid,
    input  logic [7:0]           uart_out_data,
    input  logic                 uart_out_ready,
    output logic [31:0]          mem_in_addr,
    output logic [31:0]          mem_in_data,
    output logic                 mem_in_valid,
    input  logic                 mem_in_ready,
    output logic                 load_completed,
    output logic                 load_error,
    output logic [31:0]          word_count
);

    // state   | meaning
    // S_LEN   | collecting the 4 length header bytes
    // S_WORD  | collecting the 4 bytes of the next data word
    // S_WRITE | memory write handshake in progress
    // S_CSUM  | fetching the trailer checksum byte
    // S_DONE  | all words written (terminal)
    // S_ERROR | length overflow or checksum mismatch (terminal)
    typedef enum logic [2:0] {
        S_LEN,
        S_WORD,
        S_WRITE,
        S_CSUM,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [31:0] MAX_WORDS = 32'(1) << (MEM_BIT_WIDTH - 2);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam state_t S_FINISH = S_CSUM;
`else
    localparam state_t S_FINISH = S_DONE;
`endif

    state_t      state_q, state_d;
    logic        req_q;
    logic        pend_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] asm_q;
    logic [31:0] len_q;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [31:0] count_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic        fetch;
    logic        got;
    logic        last;
    logic [31:0] full;

    assign fetch = (state_q == S_LEN) || (state_q == S_WORD) || (state_q == S_CSUM);
    // ready only counts once the request pulse has been issued
    assign got   = pend_q && uart_out_ready;
    assign last  = got && (byte_cnt_q == 2'd3);
    assign full  = {uart_out_data, asm_q};

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LEN: begin
                if (last) begin
                    if (full == 32'd0)
                        state_d = S_FINISH;
                    else if (full > MAX_WORDS)
                        state_d = S_ERROR;
                    else
                        state_d = S_WORD;
                end
            end
            S_WORD: begin
                if (last)
                    state_d = S_WRITE;
            end
            S_WRITE: begin
                if (mem_in_ready)
                    state_d = ((count_q + 32'd1) == len_q) ? S_FINISH : S_WORD;
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (got)
                    state_d = (uart_out_data == csum_q) ? S_DONE : S_ERROR;
            end
`endif
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_LEN;
            req_q      <= 1'b0;
            pend_q     <= 1'b0;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            len_q      <= 32'd0;
            addr_q     <= 32'd0;
            data_q     <= 32'd0;
            count_q    <= 32'd0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            if (req_q) begin
                req_q  <= 1'b0;
                pend_q <= 1'b1;
            end else if (fetch && !pend_q && (uart_buf_len != '0)) begin
                req_q <= 1'b1;
            end
            if (got) begin
                pend_q     <= 1'b0;
                byte_cnt_q <= byte_cnt_q + 2'd1;
                case (byte_cnt_q)
                    2'd0:    asm_q[7:0]   <= uart_out_data;
                    2'd1:    asm_q[15:8]  <= uart_out_data;
                    2'd2:    asm_q[23:16] <= uart_out_data;
                    default: asm_q        <= asm_q;
                endcase
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (state_q != S_CSUM)
                    csum_q <= csum_q ^ uart_out_data;
`endif
            end
            if ((state_q == S_LEN) && last)
                len_q <= full;
            if ((state_q == S_WORD) && last) begin
                addr_q <= {count_q[29:0], 2'b00};
                data_q <= full;
            end
            if ((state_q == S_WRITE) && mem_in_ready)
                count_q <= count_q + 32'd1;
        end
    end

    assign uart_out_valid = req_q;
    assign mem_in_valid   = (state_q == S_WRITE);
    assign mem_in_addr    = addr_q;
    assign mem_in_data    = data_q;
    assign load_completed = (state_q == S_DONE);
    assign load_error     = (state_q == S_ERROR);
    assign word_count     = count_q;

endmodule
